// File: rtl/orb_pkg.sv
// Purpose: width constants and reader FSM encoding shared by the orbital packer/reader pair.
// Latency: none; declarations only.
// Backpressure: none.
package orb_pkg;

  localparam int ORB_WORD_W      = 12;
  localparam int ORB_ADDR_W      = 11;
  localparam int ORB_FRAME_WORDS = 2048;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    LOAD,
    SHIFT
  } orbState_t;

endpackage

// File: rtl/orb_serializer.sv
// Purpose: holds one telemetry word and shifts it out MSB-first, one bit per bitTick.
// Latency: loaded word appears on orbBit the cycle after load; wordDone one cycle after the last tick.
// Backpressure: none; ticks are ignored unless shiftEn is high.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   load, loadData  capture a new word (first bit visible next cycle)
//   shiftEn         ticks only count while the owner is in its shift phase
//   bitTick         one-cycle pulse advancing to the next bit
//   orbBit          current serial bit
//   lastTick        combinational: the tick closing the final bit period is present now
//   wordDone        registered one-cycle pulse following lastTick
module orb_serializer
  import orb_pkg::*;
#(
  parameter int WORD_W = ORB_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] loadData,
  input  logic              shiftEn,
  input  logic              bitTick,
  output logic              orbBit,
  output logic              lastTick,
  output logic              wordDone
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bitCnt;
  logic              tickHit;

  assign tickHit  = shiftEn & bitTick;
  assign lastTick = tickHit & (bitCnt == CNT_W'(WORD_W - 1));
  // The output bit is the register MSB, so it is cleared by reset and
  // follows a load or shift with no extra flop.
  assign orbBit   = shreg[WORD_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      bitCnt   <= '0;
      wordDone <= 1'b0;
    end else begin
      wordDone <= lastTick;
      if (load) begin
        shreg  <= loadData;
        bitCnt <= '0;
      end else if (tickHit && !lastTick) begin
        // The final bit is left in place so the line holds it after the word ends.
        shreg  <= {shreg[WORD_W-2:0], 1'b0};
        bitCnt <= bitCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/orb_frame_reader.sv
// Purpose: fetches telemetry words from the double-buffered frame RAM and serialises them; owns page toggle SW.
// Latency: req edge to rdEn is 3 clk; rdData captured RD_LAT clk after rdEn; first bit out the cycle after capture.
// Backpressure: one word in flight; a req edge while busy is dropped and flagged in sticky overrun.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   req             asynchronous word request, one rising edge per word
//   bitTick         one-cycle bit pacing pulse
//   rdData          RAM read data, valid RD_LAT cycles after rdEn
//   rdAddr, rdEn    RAM read address and one-cycle read enable
//   orbBit          serial output, MSB first
//   busy            fetch start until the last bit period has ended
//   wordDone        one-cycle pulse after each word's last bit period
//   SW              frame page select, toggles on each frame wrap
//   frameStart      pulse with rdEn when word address 0 is fetched
//   overrun         sticky, request edge seen while busy
module orb_frame_reader
  import orb_pkg::*;
#(
  parameter int ADDR_W      = ORB_ADDR_W,
  parameter int WORD_W      = ORB_WORD_W,
  parameter int FRAME_WORDS = ORB_FRAME_WORDS,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              bitTick,
  input  logic [WORD_W-1:0] rdData,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              rdEn,
  output logic              orbBit,
  output logic              busy,
  output logic              wordDone,
  output logic              SW,
  output logic              frameStart,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  orbState_t         state, stateNxt;
  logic [1:0]        reqSync;
  logic              reqOld, reqEdge;
  logic              issue, loadWord, lastTick;
  logic [1:0]        latCnt, latCntNxt;
  logic [ADDR_W-1:0] wordCnt;

  // Two-flop synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqSync <= 2'b00;
      reqOld  <= 1'b0;
    end else begin
      reqSync <= {reqSync[0], req};
      reqOld  <= reqSync[1];
    end
  end

  assign reqEdge = reqSync[1] & ~reqOld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt;
  end

  // busy lingers for the wordDone cycle, so an edge there is refused even
  // though the FSM is already back in IDLE.
  always_comb begin
    stateNxt  = state;
    latCntNxt = latCnt;
    issue     = 1'b0;
    loadWord  = 1'b0;
    case (state)
      IDLE: begin
        if (reqEdge && !busy) begin
          issue    = 1'b1;
          stateNxt = FETCH;
        end
      end
      FETCH: begin
        latCntNxt = 2'(RD_LAT - 1);
        stateNxt  = (RD_LAT == 1) ? LOAD : WAIT;
      end
      WAIT: begin
        latCntNxt = latCnt - 2'd1;
        if (latCnt == 2'd1) stateNxt = LOAD;
      end
      LOAD: begin
        loadWord = 1'b1;
        stateNxt = SHIFT;
      end
      SHIFT: begin
        if (lastTick) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latCnt     <= 2'd0;
      rdEn       <= 1'b0;
      rdAddr     <= '0;
      frameStart <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      wordCnt    <= '0;
      SW         <= 1'b0;
    end else begin
      latCnt     <= latCntNxt;
      rdEn       <= issue;
      frameStart <= issue && (wordCnt == '0);
      if (issue) rdAddr <= wordCnt;

      if (issue)         busy <= 1'b1;
      else if (wordDone) busy <= 1'b0;

      if (reqEdge && busy) overrun <= 1'b1;

      // Counter and page flip land on the same edge that raises wordDone.
      if (lastTick) begin
        if (wordCnt == LAST_ADDR) begin
          wordCnt <= '0;
          SW      <= ~SW;
        end else begin
          wordCnt <= wordCnt + ADDR_W'(1);
        end
      end
    end
  end

  orb_serializer #(
    .WORD_W (WORD_W)
  ) uSer (
    .clk      (clk),
    .rst      (rst),
    .load     (loadWord),
    .loadData (rdData),
    .shiftEn  (state == SHIFT),
    .bitTick  (bitTick),
    .orbBit   (orbBit),
    .lastTick (lastTick),
    .wordDone (wordDone)
  );

endmodule

// File: tb/tb_orb_frame_reader.sv
module tb_orb_frame_reader;

  typedef struct {
    logic [10:0] addr;
    logic [11:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        bitTick;
  logic        req        [2];
  logic [11:0] rdData     [2];
  logic [10:0] rdAddr     [2];
  logic        rdEn       [2];
  logic        orbBit     [2];
  logic        busy       [2];
  logic        wordDone   [2];
  logic        SW         [2];
  logic        frameStart [2];
  logic        overrun    [2];

  logic [11:0] mem  [2][2048];
  logic [12:0] pipe [2][3];

  int   total = 0;
  int   bad   = 0;
  int   tickPer = 8;
  int   tickCnt = 0;
  int   expCnt [2];
  int   frameW [2];
  int   lat    [2];
  logic expSw  [2];
  logic expOv  [2];
  exp_t sbq[$];

  orb_frame_reader #(.RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .bitTick(bitTick), .rdData(rdData[0]),
    .rdAddr(rdAddr[0]), .rdEn(rdEn[0]), .orbBit(orbBit[0]), .busy(busy[0]),
    .wordDone(wordDone[0]), .SW(SW[0]), .frameStart(frameStart[0]), .overrun(overrun[0])
  );

  orb_frame_reader #(.RD_LAT(3), .FRAME_WORDS(4)) dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .bitTick(bitTick), .rdData(rdData[1]),
    .rdAddr(rdAddr[1]), .rdEn(rdEn[1]), .orbBit(orbBit[1]), .busy(busy[1]),
    .wordDone(wordDone[1]), .SW(SW[1]), .frameStart(frameStart[1]), .overrun(overrun[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running tick source; updated just after the rising edge.
  initial begin
    bitTick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tickPer <= 1) begin
        bitTick = (tickPer == 1);
      end else begin
        tickCnt = (tickCnt + 1) % tickPer;
        bitTick = (tickCnt == 0);
      end
    end
  end

  // RAM models: data valid for exactly one cycle, poison value otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= {rdEn[d], mem[d][rdAddr[d]]};
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign rdData[0] = pipe[0][0][12] ? pipe[0][0][11:0] : 12'h3C3;
  assign rdData[1] = pipe[1][2][12] ? pipe[1][2][11:0] : 12'h3C3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      expCnt[d] = 0;
      expSw[d]  = 1'b0;
      expOv[d]  = 1'b0;
    end
  endtask

  task automatic checkIdle(input int d);
    chk("rst_rdAddr", 32'(rdAddr[d]), 0);
    chk("rst_rdEn", 32'(rdEn[d]), 0);
    chk("rst_orbBit", 32'(orbBit[d]), 0);
    chk("rst_busy", 32'(busy[d]), 0);
    chk("rst_wordDone", 32'(wordDone[d]), 0);
    chk("rst_SW", 32'(SW[d]), 0);
    chk("rst_frameStart", 32'(frameStart[d]), 0);
    chk("rst_overrun", 32'(overrun[d]), 0);
  endtask

  // One word on DUT d. ovBit >= 0 raises a second request during that bit;
  // rstBit >= 0 pulls reset while that bit is on the line and abandons the word.
  task automatic runWord(input int d, input int ovBit, input int rstBit);
    exp_t e;
    int   n;
    e.addr = 11'(expCnt[d]);
    e.data = mem[d][expCnt[d]];
    sbq.push_back(e);
    @(negedge clk);
    req[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdEn[d] !== 1'b1 && n < 12);
    chk("req_to_rdEn_latency", 32'(n), 3);
    e = sbq.pop_front();
    chk("rdAddr", 32'(rdAddr[d]), 32'(e.addr));
    chk("frameStart", 32'(frameStart[d]), 32'(e.addr == 0));
    chk("busy_at_fetch", 32'(busy[d]), 1);
    req[d] = 1'b0;
    repeat (lat[d] + 1) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      n = 0;
      while (bitTick !== 1'b1 && n < 24) begin
        @(negedge clk);
        n++;
      end
      if (n >= 24) chk("tick_timeout", 1, 0);
      if (i == rstBit) begin
        rst = 1'b0;
        #1;
        checkIdle(d);
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        return;
      end
      chk("orbBit", 32'(orbBit[d]), 32'(e.data[11-i]));
      chk("busy_in_word", 32'(busy[d]), 1);
      if (i == ovBit) begin
        req[d]   = 1'b1;
        expOv[d] = 1'b1;
      end
      @(negedge clk);
    end
    chk("wordDone", 32'(wordDone[d]), 1);
    chk("busy_at_done", 32'(busy[d]), 1);
    if (expCnt[d] == frameW[d] - 1) begin
      expCnt[d] = 0;
      expSw[d]  = ~expSw[d];
    end else begin
      expCnt[d]++;
    end
    chk("SW", 32'(SW[d]), 32'(expSw[d]));
    req[d] = 1'b0;
    @(negedge clk);
    chk("busy_after", 32'(busy[d]), 0);
    chk("wordDone_pulse", 32'(wordDone[d]), 0);
    chk("overrun", 32'(overrun[d]), 32'(expOv[d]));
  endtask

  initial begin
    rst    = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    frameW[0] = 2048; lat[0] = 1;
    frameW[1] = 4;    lat[1] = 3;
    modelReset();
    for (int i = 0; i < 2048; i++) begin
      mem[0][i] = 12'($urandom);
      mem[1][i] = 12'($urandom);
    end
    mem[0][0] = 12'hA5C;
    mem[0][1] = 12'h001;
    mem[0][2] = 12'hFFF;
    mem[1][0] = 12'h801;
    mem[1][1] = 12'h7FE;

    repeat (3) @(negedge clk);
    checkIdle(0);
    checkIdle(1);
    rst = 1'b1;
    @(negedge clk);

    // Directed words at slow tick pace: A5C, 001, FFF.
    tickPer = 8;
    runWord(0, -1, -1);
    runWord(0, -1, -1);
    runWord(0, -1, -1);
    // Tick every cycle: first tick always lands in the load cycle.
    tickPer = 1;
    runWord(0, -1, -1);
    runWord(0, -1, -1);
    // Overrun during word 5; word 6 must follow.
    tickPer = 8;
    runWord(0, 3, -1);
    chk("overrun_set", 32'(overrun[0]), 1);
    runWord(0, -1, -1);
    runWord(0, -1, -1);
    runWord(0, -1, -1);
    chk("overrun_sticky", 32'(overrun[0]), 1);
    // Reset while bit 6 of word 9 is on the line.
    runWord(0, -1, 6);
    chk("cnt_before_restart", 32'(expCnt[0]), 0);
    runWord(0, -1, -1);
    chk("SW_after_reset", 32'(SW[0]), 0);

    // Full frame wrap.
    tickPer = 1;
    for (int w = 1; w < 2048; w++) runWord(0, -1, -1);
    chk("SW_wrapped", 32'(SW[0]), 1);
    runWord(0, -1, -1);
    chk("SW_still_1", 32'(SW[0]), 1);

    // RD_LAT=3 instance with a 4-word frame: 801 pattern, two wraps.
    tickPer = 3;
    for (int w = 0; w < 4; w++) runWord(1, -1, -1);
    chk("SW1_first_wrap", 32'(SW[1]), 1);
    for (int w = 0; w < 4; w++) runWord(1, -1, -1);
    chk("SW1_second_wrap", 32'(SW[1]), 0);
    chk("overrun1_clear", 32'(overrun[1]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
